// File: rtl/rr_priority_arbiter.sv
// rr_priority_arbiter
//   N-channel arbiter for one shared resource. A stored priority mask selects
//   which requests are preferred. After a completed grant the mask moves just
//   past the last winner (round-robin), or it stays all-ones (fixed priority,
//   index 0 highest). Grants are registered and one-hot, and each one is held
//   until the resource acknowledges it or the granted channel withdraws.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   en_i         arbitration enable; gates new grants only
//   req_i[N]     per-channel level requests
//   ack_i        completion strobe for the current grant
//   gnt_o[N]     one-hot registered grant
//   gnt_valid_o  high while a grant is active
//   gnt_idx_o    binary index of the granted channel (0 when idle)
//   mask_o[N]    current priority mask
//
// state | meaning
// IDLE  | no grant outstanding, waiting for en_i and a request
// GRANT | gnt_o held for one channel until ack_i or withdrawal
module rr_priority_arbiter #(
  parameter int N       = 4,
  parameter bit RR_MODE = 1'b1,
  parameter int IW      = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic [N-1:0]  req_i,
  input  logic          ack_i,
  output logic [N-1:0]  gnt_o,
  output logic          gnt_valid_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic [N-1:0]  mask_o
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  mask_q, mask_d, mask_rr;
  logic [N-1:0]  req_x, masked, gnt_d;
  logic [IW-1:0] win_idx, idx_d;
  logic          win_any, valid_d, acked, gnt_req;

  assign acked   = (state_q == GRANT) && ack_i;
  assign gnt_req = |(req_i & gnt_o);

  // Mask after completing the current grant: only channels strictly above the
  // winner stay preferred; completing the top channel reopens every channel.
  always_comb begin
    mask_rr = '0;
    for (int i = 0; i < N; i++) begin
      mask_rr[i] = (i > int'(gnt_idx_o));
    end
    if (gnt_idx_o == IW'(N-1)) begin
      mask_rr = '1;
    end
  end

  // The winner is chosen with the post-ack mask, and the channel that just
  // completed is left out. A back-to-back grant therefore goes to the next
  // channel in the same cycle as the ack.
  always_comb begin
    mask_d = mask_q;
    if (acked && RR_MODE) begin
      mask_d = mask_rr;
    end
    req_x   = acked ? (req_i & ~gnt_o) : req_i;
    masked  = req_x & mask_d;
    win_any = |req_x;
    win_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if ((masked != '0) ? masked[i] : req_x[i]) begin
        win_idx = IW'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_o;
    idx_d   = gnt_idx_o;
    valid_d = gnt_valid_o;
    case (state_q)
      IDLE: begin
        if (en_i && win_any) begin
          state_d = GRANT;
          gnt_d   = {{(N-1){1'b0}}, 1'b1} << win_idx;
          idx_d   = win_idx;
          valid_d = 1'b1;
        end
      end
      GRANT: begin
        if (ack_i) begin
          if (en_i && win_any) begin
            gnt_d   = {{(N-1){1'b0}}, 1'b1} << win_idx;
            idx_d   = win_idx;
          end else if (!(en_i && gnt_req)) begin
            // A sole requester that is still requesting keeps its grant.
            // Any other case falls through to here and releases the grant.
            state_d = IDLE;
            gnt_d   = '0;
            idx_d   = '0;
            valid_d = 1'b0;
          end
        end else if (!gnt_req) begin
          state_d = IDLE;
          gnt_d   = '0;
          idx_d   = '0;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        idx_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      gnt_o       <= '0;
      gnt_idx_o   <= '0;
      gnt_valid_o <= 1'b0;
      mask_q      <= '1;
    end else begin
      state_q     <= state_d;
      gnt_o       <= gnt_d;
      gnt_idx_o   <= idx_d;
      gnt_valid_o <= valid_d;
      mask_q      <= mask_d;
    end
  end

  assign mask_o = mask_q;

endmodule

// File: tb/tb_rr_priority_arbiter.sv
module tb_rr_priority_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic       ack = 1'b0;
  logic [3:0] req = 4'b0;

  logic [3:0] gnt_rr, mask_rr, gnt_fp, mask_fp;
  logic [1:0] idx_rr, idx_fp;
  logic       val_rr, val_fp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_priority_arbiter #(.N(4), .RR_MODE(1'b1)) dut (
    .clk(clk), .rst(rst), .en_i(en), .req_i(req), .ack_i(ack),
    .gnt_o(gnt_rr), .gnt_valid_o(val_rr), .gnt_idx_o(idx_rr), .mask_o(mask_rr));

  rr_priority_arbiter #(.N(4), .RR_MODE(1'b0)) dut_fp (
    .clk(clk), .rst(rst), .en_i(en), .req_i(req), .ack_i(ack),
    .gnt_o(gnt_fp), .gnt_valid_o(val_fp), .gnt_idx_o(idx_fp), .mask_o(mask_fp));

  // Reference model: g is the granted channel (-1 when none). ptr is the
  // first preferred channel, so the mask covers channels ptr..3. The search
  // rotates from ptr, which yields the fallback to the lowest index.
  int rr_g, rr_ptr, fp_g, fp_ptr, tmp_g, tmp_p;

  function automatic int pick(input logic [3:0] r, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (r[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  function automatic void model_step(input int g, input int ptr, input bit rr,
                                     input bit e, input logic [3:0] r, input bit a,
                                     output int g_n, output int ptr_n);
    logic [3:0] others;
    g_n = g;
    ptr_n = ptr;
    if (g < 0) begin
      if (e && r != 4'b0) g_n = pick(r, ptr);
    end else if (a) begin
      if (rr) ptr_n = (g + 1) % 4;
      others = r & ~(4'b1 << g);
      if (!e) g_n = -1;
      else if (others != 4'b0) g_n = pick(others, ptr_n);
      else if (r[g]) g_n = g;
      else g_n = -1;
    end else if (!r[g]) begin
      g_n = -1;
    end
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_g = -1; rr_ptr = 0; fp_g = -1; fp_ptr = 0;
    end else begin
      model_step(rr_g, rr_ptr, 1'b1, en, req, ack, tmp_g, tmp_p);
      rr_g = tmp_g; rr_ptr = tmp_p;
      model_step(fp_g, fp_ptr, 1'b0, en, req, ack, tmp_g, tmp_p);
      fp_g = tmp_g; fp_ptr = tmp_p;
    end
  end

  function automatic logic [3:0] exp_gnt(input int g);
    return (g < 0) ? 4'b0 : 4'(1 << g);
  endfunction

  function automatic logic [1:0] exp_idx(input int g);
    return (g < 0) ? 2'd0 : 2'(g);
  endfunction

  function automatic logic [3:0] exp_mask(input int ptr);
    return 4'(15 & ~((1 << ptr) - 1));
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0; en = 1'b0; ack = 1'b0; req = 4'b0;
    step;
    rst = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    step;
    checks++;
    if (gnt_rr !== 4'b0 || val_rr !== 1'b0 || idx_rr !== 2'd0 || mask_rr !== 4'b1111) begin
      errors++;
      $display("FAIL reset_rr: gnt=%b valid=%b idx=%0d mask=%b, want 0000 0 0 1111", gnt_rr, val_rr, idx_rr, mask_rr);
    end
    checks++;
    if (gnt_fp !== 4'b0 || val_fp !== 1'b0 || idx_fp !== 2'd0 || mask_fp !== 4'b1111) begin
      errors++;
      $display("FAIL reset_fp: gnt=%b valid=%b idx=%0d mask=%b, want 0000 0 0 1111", gnt_fp, val_fp, idx_fp, mask_fp);
    end
    rst = 1'b1;
  endtask

  task automatic test_rr_sequence;
    logic [3:0] gseq [4];
    logic [3:0] mseq [4];
    gseq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    mseq = '{4'b1110, 4'b1100, 4'b1000, 4'b1111};
    do_reset;
    en = 1'b1; req = 4'b1111;
    step;
    checks++;
    if (gnt_rr !== 4'b0001) begin
      errors++;
      $display("FAIL rr_first: gnt=%b, want 0001", gnt_rr);
    end
    for (int k = 0; k < 4; k++) begin
      ack = 1'b1;
      step;
      ack = 1'b0;
      checks++;
      if (gnt_rr !== gseq[k] || mask_rr !== mseq[k] || val_rr !== 1'b1) begin
        errors++;
        $display("FAIL rr_seq%0d: gnt=%b mask=%b valid=%b, want %b %b 1", k, gnt_rr, mask_rr, val_rr, gseq[k], mseq[k]);
      end
      step;
      checks++;
      if (gnt_rr !== gseq[k]) begin
        errors++;
        $display("FAIL rr_hold%0d: gnt=%b, want %b", k, gnt_rr, gseq[k]);
      end
    end
  endtask

  task automatic test_fixed_priority;
    do_reset;
    req = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      en = 1'b1;
      step;
      checks++;
      if (gnt_fp !== 4'b0010 || idx_fp !== 2'd1 || mask_fp !== 4'b1111) begin
        errors++;
        $display("FAIL fixed_grant%0d: gnt=%b idx=%0d mask=%b, want 0010 1 1111", k, gnt_fp, idx_fp, mask_fp);
      end
      en = 1'b0; ack = 1'b1;
      step;
      ack = 1'b0;
      checks++;
      if (gnt_fp !== 4'b0000 || mask_fp !== 4'b1111) begin
        errors++;
        $display("FAIL fixed_ack%0d: gnt=%b mask=%b, want 0000 1111", k, gnt_fp, mask_fp);
      end
    end
  endtask

  task automatic test_fallback_withdraw;
    do_reset;
    en = 1'b1; req = 4'b0010;
    step;
    ack = 1'b1; req = 4'b0000;
    step;
    ack = 1'b0;
    checks++;
    if (gnt_rr !== 4'b0000 || mask_rr !== 4'b1100) begin
      errors++;
      $display("FAIL fb_setup: gnt=%b mask=%b, want 0000 1100", gnt_rr, mask_rr);
    end
    req = 4'b0011;
    step;
    checks++;
    if (gnt_rr !== 4'b0001 || idx_rr !== 2'd0 || val_rr !== 1'b1) begin
      errors++;
      $display("FAIL fb_grant: gnt=%b idx=%0d valid=%b, want 0001 0 1", gnt_rr, idx_rr, val_rr);
    end
    ack = 1'b1; req = 4'b0000;
    step;
    ack = 1'b0;
    checks++;
    if (mask_rr !== 4'b1110 || gnt_rr !== 4'b0000) begin
      errors++;
      $display("FAIL fb_ack: mask=%b gnt=%b, want 1110 0000", mask_rr, gnt_rr);
    end
    req = 4'b0100;
    step;
    checks++;
    if (gnt_rr !== 4'b0100 || idx_rr !== 2'd2) begin
      errors++;
      $display("FAIL wd_grant: gnt=%b idx=%0d, want 0100 2", gnt_rr, idx_rr);
    end
    req = 4'b0000;
    step;
    checks++;
    if (gnt_rr !== 4'b0000 || val_rr !== 1'b0 || mask_rr !== 4'b1110) begin
      errors++;
      $display("FAIL withdraw: gnt=%b valid=%b mask=%b, want 0000 0 1110", gnt_rr, val_rr, mask_rr);
    end
  endtask

  task automatic test_enable;
    do_reset;
    en = 1'b0; req = 4'b0011;
    for (int k = 0; k < 5; k++) begin
      step;
      checks++;
      if (gnt_rr !== 4'b0000) begin
        errors++;
        $display("FAIL en_block%0d: gnt=%b, want 0000", k, gnt_rr);
      end
    end
    en = 1'b1;
    step;
    checks++;
    if (gnt_rr !== 4'b0001) begin
      errors++;
      $display("FAIL en_grant: gnt=%b, want 0001", gnt_rr);
    end
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step;
      checks++;
      if (gnt_rr !== 4'b0001) begin
        errors++;
        $display("FAIL en_hold%0d: gnt=%b, want 0001", k, gnt_rr);
      end
    end
    ack = 1'b1;
    step;
    ack = 1'b0;
    checks++;
    if (gnt_rr !== 4'b0000 || val_rr !== 1'b0) begin
      errors++;
      $display("FAIL en_ack: gnt=%b valid=%b, want 0000 0", gnt_rr, val_rr);
    end
  endtask

  task automatic test_async_reset;
    do_reset;
    en = 1'b1; req = 4'b0100;
    step;
    ack = 1'b1; req = 4'b1000;
    step;
    ack = 1'b0;
    checks++;
    if (gnt_rr !== 4'b1000 || mask_rr !== 4'b1000) begin
      errors++;
      $display("FAIL ar_setup: gnt=%b mask=%b, want 1000 1000", gnt_rr, mask_rr);
    end
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if (gnt_rr !== 4'b0000 || idx_rr !== 2'd0 || mask_rr !== 4'b1111 || val_rr !== 1'b0) begin
      errors++;
      $display("FAIL ar_immediate: gnt=%b idx=%0d mask=%b valid=%b, want 0000 0 1111 0", gnt_rr, idx_rr, mask_rr, val_rr);
    end
    #2;
    rst = 1'b1;
    req = 4'b0100;
    step;
    checks++;
    if (gnt_rr !== 4'b0100) begin
      errors++;
      $display("FAIL ar_release: gnt=%b, want 0100", gnt_rr);
    end
  endtask

  task automatic test_random;
    do_reset;
    for (int k = 0; k < 400; k++) begin
      en  = ($urandom_range(0, 3) != 0);
      req = 4'($urandom);
      ack = ($urandom_range(0, 2) == 0);
      step;
      checks++;
      if (gnt_rr !== exp_gnt(rr_g) || idx_rr !== exp_idx(rr_g) ||
          val_rr !== (rr_g >= 0) || mask_rr !== exp_mask(rr_ptr)) begin
        errors++;
        $display("FAIL rand_rr%0d: gnt=%b idx=%0d valid=%b mask=%b, want %b %0d %b %b", k,
                 gnt_rr, idx_rr, val_rr, mask_rr, exp_gnt(rr_g), exp_idx(rr_g), rr_g >= 0, exp_mask(rr_ptr));
      end
      checks++;
      if (gnt_fp !== exp_gnt(fp_g) || idx_fp !== exp_idx(fp_g) ||
          val_fp !== (fp_g >= 0) || mask_fp !== 4'b1111) begin
        errors++;
        $display("FAIL rand_fp%0d: gnt=%b idx=%0d valid=%b mask=%b, want %b %0d %b 1111", k,
                 gnt_fp, idx_fp, val_fp, mask_fp, exp_gnt(fp_g), exp_idx(fp_g), fp_g >= 0);
      end
    end
  endtask

  initial begin
    test_reset;
    test_rr_sequence;
    test_fixed_priority;
    test_fallback_withdraw;
    test_enable;
    test_async_reset;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_priority_arbiter.md
Name: rr_priority_arbiter

Overview:
- Parametrised N-channel arbiter built around a stored priority-mask register.
- Mask resets to all-ones; updated on grant completion so the last winner drops to lowest priority (round-robin), or held all-ones (fixed priority).
- Grants are registered, one-hot and held until the granted channel acknowledges completion.
- Sits between N requesting masters and one shared resource.

Parameters:
- N, 4, number of request channels (N >= 2).
- RR_MODE, 1, 1 = round-robin mask update; 0 = fixed priority (mask stays all-ones, index 0 highest).
- IW, $clog2(N), width of the grant index output.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset (asserted when 0).
- en_i  input  1  arbitration enable; new grants are issued only when 1.
- req_i  input  N  per-channel request, level-sensitive.
- ack_i  input  1  completion strobe from the shared resource for the current grant.
- gnt_o  output  N  one-hot grant, registered.
- gnt_valid_o  output  1  1 while any grant is active (equals OR of gnt_o).
- gnt_idx_o  output  IW  binary index of the granted channel; 0 when no grant.
- mask_o  output  N  current priority-mask register contents.

Behaviour:
- Reset (rst=0, asynchronous, any state): gnt_o=0, gnt_valid_o=0, gnt_idx_o=0, mask_o=all-ones, state=IDLE. Takes effect immediately, including mid-grant. Normal operation resumes on the first clk edge after rst returns to 1.
- States: IDLE and GRANT.
- Winner selection (combinational):
  - Compute masked = req_i & mask.
  - If masked != 0, winner = lowest set index of masked.
  - Otherwise winner = lowest set index of req_i (fallback when all active requests are masked).
- IDLE:
  - If en_i=1 and req_i!=0: next edge enters GRANT, loads gnt_o=onehot(winner) and gnt_idx_o=winner.
  - Latency is one clk from request visible to grant visible.
  - Otherwise stays in IDLE.
- GRANT:
  - gnt_o is held stable regardless of en_i or other requests.
  - ack_i=1, granted req still 1, RR_MODE=1: mask <= bits strictly above winner set, i.e. ~((1<<(idx+1))-1). If idx=N-1 the mask wraps to all-ones.
  - ack_i=1, RR_MODE=0: mask unchanged (all-ones).
  - Back-to-back after ack: winner is re-evaluated in the same cycle using the updated mask and req_i with the just-acked channel excluded.
    - If en_i=1 and a winner exists, GRANT is reloaded with the new winner on the next edge; there is no idle cycle.
    - If the acked channel is the only requester, it is re-granted on that same next edge.
    - Otherwise the block returns to IDLE with gnt_o=0.
  - Withdrawal: granted channel's req_i=0 with ack_i=0 -> return to IDLE, gnt_o=0 next edge, mask unchanged.
  - Withdrawal with ack_i=1 in the same cycle: treated as a normal ack (mask updates).
- ack_i in IDLE is ignored.
- en_i=0 blocks only new grants. It never truncates an active grant, and back-to-back re-grant after ack is suppressed.
- At most one gnt_o bit is ever 1. gnt_valid_o and gnt_idx_o are registered alongside gnt_o.

Test Plan:
- N=4, RR_MODE=1, en_i=1, req_i=1111 held, ack_i pulsed 1 cycle during each grant -> gnt_o sequence 0001,0010,0100,1000,0001. mask_o after each ack: 1110,1100,1000,1111. No idle cycle between grants.
- RR_MODE=0, req_i=1010 held, ack each grant -> gnt_o=0010 every grant, mask_o stays 1111; gnt_idx_o=1.
- Fallback: mask_o=1100 (after ack on idx1), req_i=0011 -> gnt_o=0001 one cycle later; after ack mask_o=1110.
- Withdrawal: gnt_o=0100 active, req_i bit2 drops with ack_i=0 -> gnt_o=0000, gnt_valid_o=0 next edge; mask_o unchanged.
- Enable gating: en_i=0, req_i=0011 for 5 cycles -> gnt_o=0000. Raise en_i -> gnt_o=0001 next edge. Drop en_i mid-grant -> grant held until ack, then gnt_o=0000.
- Async reset mid-grant: gnt_o=1000, mask_o=1000, rst=0 between edges -> immediately gnt_o=0000, gnt_idx_o=0, mask_o=1111. After release with req_i=0100 -> gnt_o=0100 one cycle later.
